// File: rtl/stream_vigenere_engine.sv
// Byte-stream Vigenere/Caesar engine: parses CMD, LEN, key and message from a valid/ready
// source, transforms the buffered message in place and streams it back with a 0x0A terminator.
module stream_vigenere_engine #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned KEY_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       err_ovf,
  output logic       err_hdr
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned CW        = AW + 1;
  localparam int unsigned KW        = $clog2(KEY_MAX) + 1;
  localparam int unsigned KIW       = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;
  localparam int unsigned KEY_SLOTS = 1 << KIW;

  localparam logic [7:0] ChNl   = 8'h0A;
  localparam logic [7:0] ChE    = 8'h45;
  localparam logic [7:0] ChD    = 8'h44;
  localparam logic [7:0] ChQ    = 8'h3F;
  localparam logic [7:0] ChBang = 8'h21;

  typedef enum logic [2:0] {StCmd, StLen, StKey, StMsg, StProc, StSend} state_e;

  state_e state_q, state_d;

  logic [7:0]    buf_q [DEPTH];
  logic [4:0]    key_q [KEY_SLOTS];
  logic          mode_q, mode_d;
  logic [KW-1:0] klen_q, klen_d;
  logic [KW-1:0] kcnt_q, kcnt_d;
  logic [KW-1:0] kidx_q, kidx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] pidx_q, pidx_d;
  logic [CW-1:0] snd_q, snd_d;
  logic          ovf_q, ovf_d;
  logic          term_q, term_d;
  logic          err_q, err_d;
  logic [7:0]    reply_q, reply_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_hdr_q, err_hdr_d;

  logic           buf_we;
  logic [AW-1:0]  buf_waddr;
  logic [7:0]     buf_wdata;
  logic           key_we;
  logic [KIW-1:0] key_waddr;
  logic [4:0]     key_wdata;

  logic          in_fire;
  logic          cmd_ok;
  logic [7:0]    len_val;
  logic          len_ok;
  logic [7:0]    proc_byte;
  logic [4:0]    proc_key;
  logic [CW-1:0] send_len;
  logic [7:0]    send_byte;

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
  endfunction

  function automatic logic [4:0] key_shift(input logic [7:0] c);
    logic [7:0] t;
    if ((c >= 8'h41) && (c <= 8'h5A))      t = c - 8'h41;
    else if ((c >= 8'h61) && (c <= 8'h7A)) t = c - 8'h61;
    else if ((c >= 8'h30) && (c <= 8'h39)) t = c - 8'h30;
    else                                   t = c % 8'd26;
    return t[4:0];
  endfunction

  // Offsets stay in 6-bit unsigned: decrypt adds 26 before subtracting the shift.
  function automatic logic [7:0] cipher(input logic [7:0] c, input logic [4:0] k,
                                        input logic dec);
    logic [7:0] base;
    logic [7:0] diff;
    logic [5:0] sum;
    base = (c >= 8'h61) ? 8'h61 : 8'h41;
    diff = c - base;
    sum  = dec ? (diff[5:0] + 6'd26 - {1'b0, k}) : (diff[5:0] + {1'b0, k});
    if (sum >= 6'd26) sum = sum - 6'd26;
    return base + {2'b00, sum};
  endfunction

  assign in_fire   = in_valid & in_ready;
  assign cmd_ok    = (in_data == ChE) || (in_data == ChD);
  assign len_val   = ((in_data >= 8'h31) && (in_data <= 8'h39)) ? (in_data - 8'h30) : in_data;
  assign len_ok    = (len_val != 8'd0) && ({24'd0, len_val} <= KEY_MAX);
  assign proc_byte = buf_q[pidx_q[AW-1:0]];
  assign proc_key  = key_q[kidx_q[KIW-1:0]];
  assign send_len  = err_q ? CW'(1) : cnt_q;
  assign send_byte = (snd_q == send_len) ? ChNl : (err_q ? reply_q : buf_q[snd_q[AW-1:0]]);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StCmd;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCmd:  if (in_fire) state_d = cmd_ok ? StLen : StSend;
      StLen:  if (in_fire) state_d = len_ok ? StKey : StSend;
      StKey:  if (in_fire && (kcnt_q == klen_q - KW'(1))) state_d = StMsg;
      StMsg:  if (in_fire && (in_data == ChNl)) state_d = ovf_q ? StSend : StProc;
      StProc: if (pidx_q + CW'(1) >= cnt_q) state_d = StSend;
      StSend: if (term_q && out_valid_q && out_ready) state_d = StCmd;
      default: state_d = StCmd;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      StCmd, StLen, StKey, StMsg: in_ready = 1'b1;
      default:                    in_ready = 1'b0;
    endcase
    busy = (state_q != StCmd);
  end

  // Datapath next-state
  always_comb begin
    mode_d      = mode_q;
    klen_d      = klen_q;
    kcnt_d      = kcnt_q;
    kidx_d      = kidx_q;
    cnt_d       = cnt_q;
    pidx_d      = pidx_q;
    snd_d       = snd_q;
    ovf_d       = ovf_q;
    term_d      = term_q;
    err_d       = err_q;
    reply_d     = reply_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    err_ovf_d   = 1'b0;
    err_hdr_d   = 1'b0;
    buf_we      = 1'b0;
    buf_waddr   = cnt_q[AW-1:0];
    buf_wdata   = in_data;
    key_we      = 1'b0;
    key_waddr   = kcnt_q[KIW-1:0];
    key_wdata   = key_shift(in_data);

    unique case (state_q)
      StCmd: begin
        if (in_fire) begin
          cnt_d  = '0;
          ovf_d  = 1'b0;
          kcnt_d = '0;
          pidx_d = '0;
          kidx_d = '0;
          if (cmd_ok) begin
            mode_d = (in_data == ChD);
            err_d  = 1'b0;
          end else begin
            err_hdr_d = 1'b1;
            err_d     = 1'b1;
            reply_d   = ChQ;
          end
        end
      end
      StLen: begin
        if (in_fire) begin
          if (len_ok) begin
            klen_d = KW'(len_val);
          end else begin
            err_hdr_d = 1'b1;
            err_d     = 1'b1;
            reply_d   = ChQ;
          end
        end
      end
      StKey: begin
        if (in_fire) begin
          key_we = 1'b1;
          kcnt_d = kcnt_q + KW'(1);
        end
      end
      StMsg: begin
        if (in_fire) begin
          if (in_data == ChNl) begin
            if (ovf_q) begin
              err_d   = 1'b1;
              reply_d = ChBang;
            end
          end else if (cnt_q < CW'(DEPTH)) begin
            buf_we = 1'b1;
            cnt_d  = cnt_q + CW'(1);
          end else if (!ovf_q) begin
            ovf_d     = 1'b1;
            err_ovf_d = 1'b1;
          end
        end
      end
      StProc: begin
        pidx_d = pidx_q + CW'(1);
        // Only letters consume a key position.
        if ((pidx_q < cnt_q) && is_letter(proc_byte)) begin
          buf_we    = 1'b1;
          buf_waddr = pidx_q[AW-1:0];
          buf_wdata = cipher(proc_byte, proc_key, mode_q);
          kidx_d    = (kidx_q == klen_q - KW'(1)) ? '0 : kidx_q + KW'(1);
        end
      end
      StSend: begin
        if (!term_q && (!out_valid_q || out_ready)) begin
          out_valid_d = 1'b1;
          out_data_d  = send_byte;
          snd_d       = snd_q + CW'(1);
          term_d      = (snd_q == send_len);
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          term_d      = 1'b0;
        end
      end
      default: ;
    endcase

    if (state_q != StSend) begin
      snd_d  = '0;
      term_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= 1'b0;
      klen_q      <= '0;
      kcnt_q      <= '0;
      kidx_q      <= '0;
      cnt_q       <= '0;
      pidx_q      <= '0;
      snd_q       <= '0;
      ovf_q       <= 1'b0;
      term_q      <= 1'b0;
      err_q       <= 1'b0;
      reply_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_ovf_q   <= 1'b0;
      err_hdr_q   <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      klen_q      <= klen_d;
      kcnt_q      <= kcnt_d;
      kidx_q      <= kidx_d;
      cnt_q       <= cnt_d;
      pidx_q      <= pidx_d;
      snd_q       <= snd_d;
      ovf_q       <= ovf_d;
      term_q      <= term_d;
      err_q       <= err_d;
      reply_q     <= reply_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_ovf_q   <= err_ovf_d;
      err_hdr_q   <= err_hdr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      for (int i = 0; i < KEY_SLOTS; i++) key_q[i] <= '0;
    end else begin
      if (buf_we) buf_q[buf_waddr] <= buf_wdata;
      if (key_we) key_q[key_waddr] <= key_wdata;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err_ovf   = err_ovf_q;
  assign err_hdr   = err_hdr_q;

endmodule
